// File: rtl/uart_tx_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_serializer_if
// Purpose  : Handshake bundle between the register block and the UART TX serializer.
// Revision : 1.0
// ============================================================================
interface uart_tx_serializer_if;
    logic       start_TX;
    logic [7:0] tx_data;
    logic       tx_active;
    logic       TXD;
    logic       tx_done;

    modport master (
        output start_TX,
        output tx_data,
        input  tx_active,
        input  TXD,
        input  tx_done
    );

    modport slave (
        input  start_TX,
        input  tx_data,
        output tx_active,
        output TXD,
        output tx_done
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_serializer
// Purpose  : 8N1 byte serializer; 8E1/8O1 when UART_TX_PARITY_EN is defined.
// Revision : 1.0
// ============================================================================
module uart_tx_serializer #(
    parameter int BAUD_DIV   = 868,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic             sync_reset,
    uart_tx_serializer_if.slave   tx
);

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

    if (BAUD_DIV < 2 || BAUD_DIV > 65535 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_params
        $error("uart_tx_serializer: illegal parameter value");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t      state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        stop_cnt;
    logic        txd_reg;
    logic        active_reg;
    logic        done_reg;
    logic        bit_end;
`ifdef UART_TX_PARITY_EN
    logic        parity_bit;
`endif

    assign bit_end      = (baud_cnt == BAUD_LAST);
    assign tx.TXD       = txd_reg;
    assign tx.tx_active = active_reg;
    assign tx.tx_done   = done_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            stop_cnt   <= 1'b0;
            txd_reg    <= 1'b1;
            active_reg <= 1'b0;
            done_reg   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else if (sync_reset) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            stop_cnt   <= 1'b0;
            txd_reg    <= 1'b1;
            active_reg <= 1'b0;
            done_reg   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            if (state != IDLE) begin
                baud_cnt <= bit_end ? 16'd0 : baud_cnt + 16'd1;
            end

            case (state)
                IDLE: begin
                    txd_reg    <= 1'b1;
                    active_reg <= 1'b0;
                    if (tx.start_TX) begin
                        shift      <= tx.tx_data;
                        baud_cnt   <= '0;
                        bit_idx    <= '0;
                        state      <= START;
                        txd_reg    <= 1'b0;
                        active_reg <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        // Taken from the input byte because shift is consumed as bits go out.
                        parity_bit <= (^tx.tx_data) ^ PARITY_ODD[0];
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        txd_reg <= shift[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift   <= {1'b0, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
                            state    <= PARITY;
                            txd_reg  <= parity_bit;
`else
                            state    <= STOP;
                            txd_reg  <= 1'b1;
`endif
                        end else begin
                            txd_reg <= shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state   <= STOP;
                        txd_reg <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        if (stop_cnt == STOP_LAST) begin
                            state      <= IDLE;
                            active_reg <= 1'b0;
                            done_reg   <= 1'b1;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    txd_reg    <= 1'b1;
                    active_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Byte-wide asynchronous serial transmitter directly downstream of the memory-mapped register block.
- Consumes the start_TX strobe and tx_data byte produced on a write to the UART TX address.
- Returns tx_active, which the register block exposes to software as the busy flag (bit 31 of the TX address read).
- Drives the TXD pin with 8N1 framing, or 8E1/8O1 when the parity option is compiled in.

Parameters:
- BAUD_DIV, 868, clocks per serial bit (100 MHz / 115200); legal range 2..65535.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.
- PARITY_ODD, 0, parity sense when UART_TX_PARITY_EN is defined (0 = even, 1 = odd); ignored otherwise.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  reset, asynchronous, active-low.
- sync_reset  input  1  synchronous reset, active-high; same effect as reset_n, applied at the clock edge.
- start_TX  input  1  single-cycle request to send tx_data.
- tx_data  input  8  byte to send; sampled only in the cycle start_TX is accepted.
- tx_active  output  1  high while a frame is in flight (busy).
- TXD  output  1  serial line; idle level is 1.
- tx_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (reset_n low, or sync_reset high at an edge):
  - Outputs: TXD=1, tx_active=0, tx_done=0.
  - Internal state: state=IDLE, baud counter=0, bit index=0, shift register=0.
  - Reset mid-frame aborts the frame immediately; no partial stop bit is sent.
- States: IDLE, START, DATA, PARITY (only with option), STOP.
- Bit timing:
  - A 16-bit baud counter counts 0..BAUD_DIV-1 in every non-IDLE state.
  - The bit boundary is the cycle where counter==BAUD_DIV-1; the counter then wraps to 0.
  - Every bit lasts exactly BAUD_DIV clocks.
- IDLE:
  - TXD=1, tx_active=0.
  - start_TX=1 latches tx_data into the shift register and clears the counter and bit index.
  - Next cycle: state=START, TXD=0, tx_active=1. Latency from the start_TX edge to the start bit is 1 cycle.
- START:
  - TXD=0 for BAUD_DIV clocks.
  - At the bit boundary: go to DATA.
- DATA:
  - TXD=shift[0]; LSB first.
  - At each boundary: shift right by 1 and increment the bit index.
  - After bit index 7 completes: go to PARITY if the option is compiled in, else STOP.
- STOP:
  - TXD=1 for STOP_BITS*BAUD_DIV clocks, using an internal stop-bit count.
  - At the final boundary: state=IDLE, tx_active=0, and tx_done=1 for exactly one cycle (the first IDLE cycle).
- Busy handling:
  - tx_active is registered and equals (state != IDLE).
  - start_TX is accepted only in IDLE.
  - start_TX while busy, including the last STOP cycle, is dropped silently: no queueing, no corruption of the frame in flight.
  - Software must poll tx_active.
- Back-to-back frames: start_TX in the same cycle tx_done=1 is accepted. Minimum frame-to-frame gap is 0 idle bit times beyond the stop bit(s), plus the 1-cycle accept latency.
- Glitch-free TXD: TXD is driven from a flop, never decoded combinationally.
- Frame length in clocks: (1 + 8 + P + STOP_BITS) * BAUD_DIV, where P is 1 with the option compiled in and 0 without.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP, lasting BAUD_DIV clocks.
  - TXD = (XOR of the latched byte) XOR PARITY_ODD.
  - Parity is computed at accept time from tx_data, not from the shifting register.
- Undefined: no PARITY state and no parity logic; DATA goes directly to STOP and PARITY_ODD has no effect.

Test Plan:
- Basic byte, no parity: BAUD_DIV=4, STOP_BITS=1, start_TX with tx_data=8'hA5.
  - TXD sequence per 4-clock bit: 0,1,0,1,0,0,1,0,1,1.
  - tx_active high for 40 cycles starting 1 cycle after start_TX; tx_done pulses once at cycle 41.
- Busy drop: during the frame of 8'h3C, pulse start_TX with 8'hFF at cycle 20 and again at cycle 40 (last STOP cycle).
  - Line carries only 8'h3C; exactly one tx_done.
- Back-to-back: issue start_TX with 8'h55 in the tx_done cycle of the prior frame.
  - Second start bit begins the next cycle; no extra idle bit on the line.
- Parity, 2 stop bits: UART_TX_PARITY_EN defined, PARITY_ODD=0, STOP_BITS=2, BAUD_DIV=4, data 8'h07.
  - Parity bit=1; frame is 48 cycles.
  - Repeat with PARITY_ODD=1: parity bit=0.
- Resets mid-frame:
  - Assert sync_reset at cycle 15 of a frame: next edge gives TXD=1, tx_active=0, tx_done=0.
  - Repeat with a reset_n pulse: immediate return to the same values.
  - A new start_TX afterwards produces a clean full frame.
- Full-rate divider: BAUD_DIV=868, data 8'h00.
  - Start bit and the 8 data bits each stay at 0 for exactly 868 clocks, i.e. TXD is 0 for 7812 clocks total.
  - Stop bit is 868 clocks high.
